fib_seq_ctrl: RTL and testbench

- Sequencing controller for the 11-bit Fibonacci datapath (n-1 register, n-2 register, ripple-carry adder, seed mux). It replaces the bare button/RCO FSM and the external 4-bit term counter.
- Adds rising-edge start detection, step pacing from a slow tick enable, a configurable term count, per-term valid strobes, and done/overflow status.
- Sits between the board button/clock-divider tick and the datapath load/clear/select controls.

---
 rtl/fib_seq_ctrl.sv | 125 ++++++++++++
 tb/tb_fib_seq_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fib_seq_ctrl
// Description : Sequencing controller for the 11-bit Fibonacci datapath.
//               Edge-triggered start, tick-paced stepping, term counting,
//               per-term valid strobes and done/overflow status.
// Revision    : 1.0 - initial release
// ============================================================================
module fib_seq_ctrl #(
    parameter int N_TERMS = 16,
    parameter int CW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step_en,
    input  logic          ovf,
    output logic          mux_sel,
    output logic          clr,
    output logic          ld1,
    output logic          ld2,
    output logic          busy,
    output logic          valid,
    output logic [CW-1:0] term_idx,
    output logic          done,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_SEED = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [CW-1:0] c_LAST_IDX = CW'(N_TERMS - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic          r_start_q;
    logic          w_start_edge;
    logic [CW-1:0] w_idx_inc;

    assign w_start_edge = start & ~r_start_q;
    assign w_idx_inc    = term_idx + CW'(1);

    always_comb begin
        w_next_state = r_state;
        mux_sel      = 1'b0;
        clr          = rst;
        ld1          = 1'b0;
        ld2          = 1'b0;
        busy         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_edge) w_next_state = S_INIT;
            end
            S_INIT: begin
                clr          = 1'b1;
                busy         = 1'b1;
                w_next_state = S_SEED;
            end
            S_SEED: begin
                mux_sel      = 1'b1;
                ld1          = 1'b1;
                busy         = 1'b1;
                w_next_state = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                ld1  = step_en;
                ld2  = step_en;
                if (step_en && ((w_idx_inc == c_LAST_IDX) || ovf))
                    w_next_state = S_DONE;
            end
            S_DONE: begin
                if (w_start_edge) w_next_state = S_INIT;
            end
            default: w_next_state = S_IDLE;
        endcase
        // Reset overrides everything except clr so the datapath sees only a clear.
        if (rst) begin
            mux_sel = 1'b0;
            ld1     = 1'b0;
            ld2     = 1'b0;
            busy    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // start_q keeps tracking the button through reset so a held press never fires.
        r_start_q <= start;
        if (rst) begin
            r_state  <= S_IDLE;
            term_idx <= '0;
            valid    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            valid   <= 1'b0;
            done    <= (w_next_state == S_DONE);
            case (r_state)
                S_INIT: begin
                    term_idx <= '0;
                    err      <= 1'b0;
                end
                S_SEED: begin
                    valid <= 1'b1;
                end
                S_RUN: begin
                    if (step_en) begin
                        term_idx <= w_idx_inc;
                        valid    <= 1'b1;
                        if (ovf) err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fib_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fib_seq_ctrl
// Description : Scoreboard bench for fib_seq_ctrl driving an 11-bit datapath model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fib_seq_ctrl;

    localparam int N_TERMS = 16;
    localparam int CW      = 4;

    logic          clk = 1'b0;
    logic          rst, start, step_en, ovf, ovf_force;
    logic          mux_sel, clr, ld1, ld2, busy, valid, done, err;
    logic [CW-1:0] term_idx;

    logic [10:0] n1, n2;
    logic [11:0] sum;

    typedef struct { int idx; int val; } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    int fib_tab[16] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610};
    int errors  = 0;
    int checks  = 0;
    int clr_cnt = 0;

    always #5 clk = ~clk;

    fib_seq_ctrl #(.N_TERMS(N_TERMS), .CW(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .step_en  (step_en),
        .ovf      (ovf),
        .mux_sel  (mux_sel),
        .clr      (clr),
        .ld1      (ld1),
        .ld2      (ld2),
        .busy     (busy),
        .valid    (valid),
        .term_idx (term_idx),
        .done     (done),
        .err      (err)
    );

    // Datapath: n-1 and n-2 registers with seed mux and adder.
    assign sum = {1'b0, n1} + {1'b0, n2};
    assign ovf = sum[11] | ovf_force;

    always @(posedge clk) begin
        if (clr) begin
            n1 <= '0;
            n2 <= '0;
        end else begin
            if (ld1) n1 <= mux_sel ? 11'd1 : sum[10:0];
            if (ld2) n2 <= n1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && clr) clr_cnt++;
        if (valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got term_idx %0d expected no strobe", term_idx);
            end else begin
                mon_e = exp_q.pop_front();
                check("term_idx", int'(term_idx), mon_e.idx);
                check("term_val", int'(n2), mon_e.val);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_terms(input int last);
        for (int i = 0; i <= last; i++) exp_q.push_back('{i, fib_tab[i]});
    endtask

    // Start edge, then INIT and SEED; returns with the DUT in RUN.
    task automatic launch();
        start = 1'b1;
        repeat (3) tick();
    endtask

    task automatic run_steps(input int nsteps, input int ovf_at, input int drop_at);
        for (int s = 1; s <= nsteps; s++) begin
            repeat (3) tick();
            if (s == drop_at) start = 1'b0;
            if (drop_at > 0 && s == drop_at + 1) start = 1'b1;
            step_en   = 1'b1;
            ovf_force = (s == ovf_at);
            tick();
            step_en   = 1'b0;
            ovf_force = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b1; step_en = 1'b0; ovf_force = 1'b0;

        // Reset with start held
        tick();
        check("clr_in_rst", clr, 1);
        tick();
        check("rst_valid", valid, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_term_idx", int'(term_idx), 0);
        check("rst_busy", busy, 0);
        check("rst_ld1", ld1, 0);
        check("rst_ld2", ld2, 0);
        check("rst_mux_sel", mux_sel, 0);
        check("rst_clr", clr, 1);
        rst = 1'b0;
        repeat (5) tick();
        check("held_start_busy", busy, 0);
        check("held_start_clr", clr, 0);
        check("held_start_done", done, 0);
        start = 1'b0;
        tick();

        // Full run
        push_terms(15);
        launch();
        run_steps(15, 0, 0);
        start = 1'b0;
        repeat (2) tick();
        check("full_done", done, 1);
        check("full_err", err, 0);
        check("full_term_idx", int'(term_idx), 15);
        check("full_busy", busy, 0);
        check("full_queue", exp_q.size(), 0);
        step_en = 1'b1;
        #1;
        check("done_ld1", ld1, 0);
        check("done_ld2", ld2, 0);
        tick();
        step_en = 1'b0;
        check("done_hold", done, 1);
        check("done_value", int'(n2), 610);

        // Held start and duplicate edge mid-run, restarting from DONE
        push_terms(15);
        launch();
        run_steps(15, 0, 12);
        repeat (2) tick();
        check("dup_done", done, 1);
        check("dup_term_idx", int'(term_idx), 15);
        check("dup_queue", exp_q.size(), 0);
        repeat (5) tick();
        check("dup_no_retrigger", done, 1);
        start = 1'b0;
        tick();

        // Overflow on the 5th step
        push_terms(5);
        launch();
        run_steps(5, 5, 0);
        start = 1'b0;
        repeat (2) tick();
        check("ovf_done", done, 1);
        check("ovf_err", err, 1);
        check("ovf_term_idx", int'(term_idx), 5);
        check("ovf_busy", busy, 0);
        check("ovf_queue", exp_q.size(), 0);

        // Restart from DONE clears status
        clr_cnt = 0;
        push_terms(15);
        start = 1'b1;
        tick();
        tick();
        check("restart_err", err, 0);
        check("restart_term_idx", int'(term_idx), 0);
        check("restart_done", done, 0);
        check("restart_busy", busy, 1);
        tick();
        run_steps(15, 0, 0);
        tick();
        check("restart_final_done", done, 1);
        check("restart_final_err", err, 0);
        check("restart_clr_pulses", clr_cnt, 1);
        check("restart_queue", exp_q.size(), 0);
        start = 1'b0;
        tick();

        // Reset mid-run at term_idx 7
        push_terms(7);
        launch();
        run_steps(7, 0, 0);
        check("mid_term_idx", int'(term_idx), 7);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_term_idx", int'(term_idx), 0);
        check("midrst_done", done, 0);
        check("midrst_valid", valid, 0);
        check("midrst_busy", busy, 0);
        tick();
        check("midrst_idle", busy, 0);
        check("midrst_queue", exp_q.size(), 0);
        start = 1'b0;
        tick();
        push_terms(15);
        launch();
        run_steps(15, 0, 0);
        tick();
        check("post_done", done, 1);
        check("post_term_idx", int'(term_idx), 15);
        check("post_value", int'(n2), 610);
        check("post_queue", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
